// File: rtl/xmailbox_pkg.sv
// Shared definitions for the controller mailbox: register offsets, STATUS
// field positions and CTRL action bits.
package xmailbox_pkg;

    typedef enum logic [1:0] {
        MBX_DATA   = 2'd0,
        MBX_STATUS = 2'd1,
        MBX_CTRL   = 2'd2,
        MBX_THRESH = 2'd3
    } mbx_reg_e;

    localparam int ST_RX_EMPTY   = 0;
    localparam int ST_RX_FULL    = 1;
    localparam int ST_TX_EMPTY   = 2;
    localparam int ST_TX_FULL    = 3;
    localparam int ST_RX_UDF     = 4;
    localparam int ST_TX_OVF     = 5;
    localparam int ST_RX_CNT_LSB = 8;
    localparam int ST_TX_CNT_LSB = 16;
    localparam int ST_CNT_W      = 8;

    localparam int CTRL_FLUSH = 0;
    localparam int CTRL_CLR   = 1;

endpackage

// File: rtl/xmailbox_if.sv
// Controller bus port plus TX/RX stream handshakes of the mailbox.
interface xmailbox_if #(
    parameter int DATA_W = 32
);
    logic              sel;
    logic              we;
    logic [1:0]        addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_to_rd;
    logic              irq;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              rx_ready;

    modport master (
        output sel, we, addr, data_in, tx_ready, rx_valid, rx_data,
        input  data_to_rd, irq, tx_valid, tx_data, rx_ready
    );

    modport slave (
        input  sel, we, addr, data_in, tx_ready, rx_valid, rx_data,
        output data_to_rd, irq, tx_valid, tx_data, rx_ready
    );
endinterface

// File: rtl/xmailbox_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; push/pop are ignored
// when full/empty so the count can never wrap.
module mbx_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset; stale words are never visible while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/xmailbox.sv
// Memory-mapped mailbox: controller loads/stores bridged to TX and RX
// streaming FIFOs, with status/control registers and an RX level interrupt.
module xmailbox
    import xmailbox_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic     clk,
    input  logic     rst,
    xmailbox_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    mbx_reg_e          reg_sel;
    logic              rd_op;
    logic              wr_op;
    logic              flush;
    logic              clr;
    logic              tx_push;
    logic              tx_pop;
    logic              rx_push;
    logic              rx_pop;
    logic [CNT_W-1:0]  tx_count;
    logic [CNT_W-1:0]  rx_count;
    logic [CNT_W-1:0]  rx_count_next;
    logic [CNT_W-1:0]  thresh;
    logic              tx_empty;
    logic              tx_full;
    logic              rx_empty;
    logic              rx_full;
    logic [DATA_W-1:0] tx_dout;
    logic [DATA_W-1:0] rx_dout;
    logic [DATA_W-1:0] status;
    logic [DATA_W-1:0] rd_mux;
    logic [DATA_W-1:0] rd_q;
    logic              rx_udf;
    logic              tx_ovf;
    logic              irq_q;

    assign reg_sel = mbx_reg_e'(bus.addr);

    always_comb begin
        rd_op   = bus.sel & ~bus.we;
        wr_op   = bus.sel & bus.we;
        flush   = wr_op && (reg_sel == MBX_CTRL) && bus.data_in[CTRL_FLUSH];
        clr     = wr_op && (reg_sel == MBX_CTRL) && bus.data_in[CTRL_CLR];
        tx_push = wr_op && (reg_sel == MBX_DATA) && !tx_full;
        tx_pop  = !tx_empty && bus.tx_ready;
        rx_push = bus.rx_valid && !rx_full;
        rx_pop  = rd_op && (reg_sel == MBX_DATA) && !rx_empty;
    end

    mbx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .flush (flush),
        .din   (bus.data_in),
        .dout  (tx_dout),
        .count (tx_count),
        .empty (tx_empty),
        .full  (tx_full)
    );

    mbx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .flush (flush),
        .din   (bus.rx_data),
        .dout  (rx_dout),
        .count (rx_count),
        .empty (rx_empty),
        .full  (rx_full)
    );

    // Next RX occupancy mirrors the FIFO update so irq lands with the count.
    always_comb begin
        rx_count_next = flush ? '0 : rx_count + CNT_W'(rx_push) - CNT_W'(rx_pop);
    end

    always_comb begin
        status                                 = '0;
        status[ST_RX_EMPTY]                    = rx_empty;
        status[ST_RX_FULL]                     = rx_full;
        status[ST_TX_EMPTY]                    = tx_empty;
        status[ST_TX_FULL]                     = tx_full;
        status[ST_RX_UDF]                      = rx_udf;
        status[ST_TX_OVF]                      = tx_ovf;
        status[ST_RX_CNT_LSB +: ST_CNT_W]      = ST_CNT_W'(rx_count);
        status[ST_TX_CNT_LSB +: ST_CNT_W]      = ST_CNT_W'(tx_count);
    end

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            MBX_DATA:   rd_mux = rx_empty ? '0 : rx_dout;
            MBX_STATUS: rd_mux = status;
            MBX_CTRL:   rd_mux = '0;
            MBX_THRESH: rd_mux = DATA_W'(thresh);
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q   <= '0;
            irq_q  <= 1'b0;
            rx_udf <= 1'b0;
            tx_ovf <= 1'b0;
            thresh <= CNT_W'(1);
        end else begin
            if (rd_op) rd_q <= rd_mux;
            if (clr) begin
                rx_udf <= 1'b0;
                tx_ovf <= 1'b0;
            end else begin
                if (rd_op && (reg_sel == MBX_DATA) && rx_empty) rx_udf <= 1'b1;
                if (wr_op && (reg_sel == MBX_DATA) && tx_full)  tx_ovf <= 1'b1;
            end
            if (wr_op && (reg_sel == MBX_THRESH)) thresh <= bus.data_in[CNT_W-1:0];
            irq_q <= (thresh != '0) && (rx_count_next >= thresh);
        end
    end

    assign bus.data_to_rd = rd_q;
    assign bus.irq        = irq_q;
    assign bus.tx_valid   = ~tx_empty;
    assign bus.tx_data    = tx_dout;
    assign bus.rx_ready   = ~rx_full;

endmodule

// File: tb/tb_xmailbox.sv
// Directed scenarios plus randomized traffic against a queue-based model.
module tb_xmailbox;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xmailbox_if #(.DATA_W(DW)) mb ();
    xmailbox #(.DATA_W(DW), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(mb));

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    bit          m_udf, m_ovf, m_irq;
    int          m_thresh;
    logic [31:0] m_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        int rn, tn;
        rn       = rx_q.size();
        tn       = tx_q.size();
        s        = '0;
        s[0]     = (rn == 0);
        s[1]     = (rn == DEPTH);
        s[2]     = (tn == 0);
        s[3]     = (tn == DEPTH);
        s[4]     = m_udf;
        s[5]     = m_ovf;
        s[15:8]  = rn[7:0];
        s[23:16] = tn[7:0];
        return s;
    endfunction

    // One clock: drive inputs, advance the model, then check at the falling edge.
    task automatic step(input bit r, input bit s, input bit w, input logic [1:0] a,
                        input logic [31:0] d, input bit trdy, input bit rv,
                        input logic [31:0] rdat);
        bit rd_op, wr_op, fl, cl;
        int tn0, rn0, th_old;
        rst = r; mb.sel = s; mb.we = w; mb.addr = a; mb.data_in = d;
        mb.tx_ready = trdy; mb.rx_valid = rv; mb.rx_data = rdat;
        if (r) begin
            tx_q.delete(); rx_q.delete();
            m_udf = 0; m_ovf = 0; m_irq = 0; m_thresh = 1; m_rd = '0;
        end else begin
            rd_op  = s && !w;
            wr_op  = s && w;
            fl     = wr_op && a == 2'd2 && d[0];
            cl     = wr_op && a == 2'd2 && d[1];
            tn0    = tx_q.size();
            rn0    = rx_q.size();
            th_old = m_thresh;
            if (rd_op) begin
                case (a)
                    2'd0:    m_rd = (rn0 > 0) ? rx_q[0] : 32'h0;
                    2'd1:    m_rd = m_status();
                    2'd2:    m_rd = 32'h0;
                    default: m_rd = 32'(m_thresh);
                endcase
            end
            if (rd_op && a == 2'd0 && rn0 == 0)     m_udf = 1;
            if (wr_op && a == 2'd0 && tn0 == DEPTH) m_ovf = 1;
            if (cl) begin m_udf = 0; m_ovf = 0; end
            if (fl) begin
                tx_q.delete(); rx_q.delete();
            end else begin
                if (tn0 > 0 && trdy)                     void'(tx_q.pop_front());
                if (wr_op && a == 2'd0 && tn0 < DEPTH)   tx_q.push_back(d);
                if (rd_op && a == 2'd0 && rn0 > 0)       void'(rx_q.pop_front());
                if (rv && rn0 < DEPTH)                   rx_q.push_back(rdat);
            end
            m_irq = (th_old != 0) && (rx_q.size() >= th_old);
            if (wr_op && a == 2'd3) m_thresh = int'(d[CNT_W-1:0]);
        end
        @(posedge clk);
        @(negedge clk);
        check("data_to_rd", mb.data_to_rd, m_rd);
        check("irq", 32'(mb.irq), 32'(m_irq));
        check("tx_valid", 32'(mb.tx_valid), 32'(tx_q.size() != 0));
        if (tx_q.size() != 0) check("tx_data", mb.tx_data, tx_q[0]);
        check("rx_ready", 32'(mb.rx_ready), 32'(rx_q.size() < DEPTH));
    endtask

    task automatic idle(input bit trdy, input bit rv, input logic [31:0] rdat);
        step(0, 0, 0, 2'd0, 32'h0, trdy, rv, rdat);
    endtask

    task automatic rd_reg(input logic [1:0] a);
        step(0, 1, 0, a, 32'h0, 0, 0, 32'h0);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        step(0, 1, 1, a, d, 0, 0, 32'h0);
    endtask

    initial begin
        bit s, w, trdy, rv, rr;
        logic [1:0] a;
        logic [31:0] d;
        int bias;
        rst = 1; mb.sel = 0; mb.we = 0; mb.addr = 0; mb.data_in = 0;
        mb.tx_ready = 0; mb.rx_valid = 0; mb.rx_data = 0;
        @(negedge clk);
        step(1, 0, 0, 2'd0, 32'h0, 0, 0, 32'h0);
        step(1, 0, 0, 2'd0, 32'h0, 0, 0, 32'h0);

        rd_reg(2'd1);
        check("reset_status", mb.data_to_rd, 32'h5);
        check("reset_rx_ready", 32'(mb.rx_ready), 32'h1);
        check("reset_tx_valid", 32'(mb.tx_valid), 32'h0);
        check("reset_irq", 32'(mb.irq), 32'h0);
        rd_reg(2'd3);
        check("reset_thresh", mb.data_to_rd, 32'h1);

        for (int i = 0; i < 3; i++) wr_reg(2'd0, 32'hA1 + 32'(i));
        rd_reg(2'd1);
        check("tx_count_3", 32'(mb.data_to_rd[23:16]), 32'h3);
        for (int i = 0; i < 3; i++) begin
            check("tx_order", mb.tx_data, 32'hA1 + 32'(i));
            idle(1, 0, 32'h0);
        end
        rd_reg(2'd1);
        check("tx_count_0", 32'(mb.data_to_rd[23:16]), 32'h0);

        for (int i = 0; i < 9; i++) wr_reg(2'd0, 32'hB0 + 32'(i));
        rd_reg(2'd1);
        check("tx_full", 32'(mb.data_to_rd[3]), 32'h1);
        check("tx_ovf_set", 32'(mb.data_to_rd[5]), 32'h1);
        check("tx_count_8", 32'(mb.data_to_rd[23:16]), 32'h8);
        wr_reg(2'd2, 32'h2);
        rd_reg(2'd1);
        check("tx_ovf_clr", 32'(mb.data_to_rd[5]), 32'h0);
        wr_reg(2'd2, 32'h1);

        wr_reg(2'd3, 32'h3);
        idle(0, 1, 32'h11);
        idle(0, 1, 32'h22);
        check("irq_below", 32'(mb.irq), 32'h0);
        idle(0, 1, 32'h33);
        check("irq_at_thresh", 32'(mb.irq), 32'h1);
        rd_reg(2'd0);
        check("rx_head", mb.data_to_rd, 32'h11);
        check("irq_drop", 32'(mb.irq), 32'h0);
        for (int i = 0; i < 6; i++) idle(0, 1, 32'hC0 + 32'(i));
        check("rx_full_ready", 32'(mb.rx_ready), 32'h0);

        wr_reg(2'd2, 32'h1);
        rd_reg(2'd0);
        check("rx_empty_read", mb.data_to_rd, 32'h0);
        rd_reg(2'd1);
        check("rx_udf_set", 32'(mb.data_to_rd[4]), 32'h1);

        for (int i = 0; i < 4; i++) idle(0, 1, 32'hD0 + 32'(i));
        step(0, 1, 0, 2'd0, 32'h0, 0, 1, 32'hD4);
        check("rx_simul_data", mb.data_to_rd, 32'hD0);
        rd_reg(2'd1);
        check("rx_simul_count", 32'(mb.data_to_rd[15:8]), 32'h4);

        wr_reg(2'd0, 32'hE0);
        wr_reg(2'd0, 32'hE1);
        step(0, 1, 1, 2'd2, 32'h1, 1, 1, 32'hE2);
        check("flush_rx_ready", 32'(mb.rx_ready), 32'h1);
        check("flush_tx_valid", 32'(mb.tx_valid), 32'h0);
        rd_reg(2'd1);
        check("flush_counts", 32'(mb.data_to_rd[23:8]), 32'h0101 & 32'h0);
        check("flush_keeps_udf", 32'(mb.data_to_rd[4]), 32'h1);

        for (int n = 0; n < 4000; n++) begin
            if (n % 250 == 0) bias = int'($urandom_range(0, 2));
            rr   = ($urandom_range(0, 799) == 0);
            s    = ($urandom_range(0, 3) != 0);
            w    = $urandom_range(0, 1);
            a    = 2'($urandom_range(0, 3));
            d    = $urandom;
            if (s && w && a == 2'd2) d = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(1, 3)) : 32'h2;
            if (s && w && a == 2'd3) d = 32'($urandom_range(0, DEPTH));
            trdy = (bias == 0) ? ($urandom_range(0, 3) == 0) : (bias == 1) ? ($urandom_range(0, 3) != 0) : $urandom_range(0, 1);
            rv   = (bias == 1) ? ($urandom_range(0, 3) == 0) : (bias == 0) ? ($urandom_range(0, 3) != 0) : $urandom_range(0, 1);
            step(rr, s, w, a, d, trdy, rv, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
